// File: rtl/display_formatter.sv
// Nine-digit seven-segment formatter: snapshots digit registers on a frame tick,
// encodes one digit per cycle into a staging image, then commits all 72 bits at once.
module display_formatter #(
    parameter int BLINK_FRAMES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [6:0]  wr_data,
    input  logic        frame_tick,
    output logic [71:0] display_bits,
    output logic        busy,
    output logic        frame_missed,
    output logic [1:0]  dbg_state
);

    // Handshake: frame_tick is a one-cycle request accepted only while busy is low;
    // a request seen while busy is dropped and reported by frame_missed on the next cycle.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENCODE = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [6:0]  r_digit [9];
    logic [6:0]  r_shadow [9];
    logic        r_shadow_phase;
    logic        r_blink_phase;
    logic [7:0]  r_blink_cnt;
    logic [3:0]  r_idx;
    logic [71:0] r_staging;
    logic [71:0] r_display;
    logic        r_missed;
    logic [7:0]  w_enc_byte;

    function automatic logic [7:0] encode_digit(input logic [6:0] d, input logic phase);
        logic [6:0] seg;
        case (d[3:0])
            4'h0: seg = 7'h3F;  4'h1: seg = 7'h06;  4'h2: seg = 7'h5B;  4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;  4'h5: seg = 7'h6D;  4'h6: seg = 7'h7D;  4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;  4'h9: seg = 7'h6F;  4'hA: seg = 7'h77;  4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;  4'hD: seg = 7'h5E;  4'hE: seg = 7'h79;  default: seg = 7'h71;
        endcase
        if (d[5] || (d[6] && phase)) begin
            encode_digit = 8'h00;
        end else begin
            encode_digit = {d[4], seg};
        end
    endfunction

    assign w_enc_byte = encode_digit(r_shadow[r_idx], r_shadow_phase);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (frame_tick) w_next = S_ENCODE;
            S_ENCODE: if (r_idx == 4'd8) w_next = S_COMMIT;
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Digit registers keep accepting writes regardless of encode progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) r_digit[i] <= 7'b0100000;
        end else if (wr_en && (wr_addr <= 4'd8)) begin
            r_digit[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) r_shadow[i] <= 7'b0100000;
            r_shadow_phase <= 1'b0;
            r_blink_phase  <= 1'b0;
            r_blink_cnt    <= 8'd0;
            r_idx          <= 4'd0;
            r_staging      <= 72'd0;
            r_display      <= 72'd0;
            r_missed       <= 1'b0;
        end else begin
            r_missed <= frame_tick && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (frame_tick) begin
                        r_shadow       <= r_digit;
                        r_shadow_phase <= r_blink_phase;
                        r_idx          <= 4'd0;
                        if (r_blink_cnt == 8'(BLINK_FRAMES - 1)) begin
                            r_blink_cnt   <= 8'd0;
                            r_blink_phase <= ~r_blink_phase;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + 8'd1;
                        end
                    end
                end
                S_ENCODE: begin
                    r_staging[{r_idx, 3'b000} +: 8] <= w_enc_byte;
                    r_idx                           <= r_idx + 4'd1;
                end
                S_COMMIT: r_display <= r_staging;
                default: ;
            endcase
        end
    end

    assign display_bits = r_display;
    assign busy         = (r_state != S_IDLE);
    assign frame_missed = r_missed;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_display_formatter.sv
// Directed bench for display_formatter: frame latency, encoding, blink, write hazards, reset.
module tb_display_formatter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [6:0]  wr_data;
    logic        frame_tick;
    logic [71:0] display_bits;
    logic        busy;
    logic        frame_missed;
    logic [1:0]  dbg_state;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [71:0] exp_q[$];

    localparam logic [71:0] F0 = 72'h7F_07_7D_6D_66_4F_5B_06_3F;
    localparam logic [71:0] F1 = 72'h7F_07_7D_6D_66_F7_5B_06_3F;
    localparam logic [71:0] F2 = 72'h7F_07_7D_6D_66_00_5B_06_3F;
    localparam logic [71:0] F4 = 72'h7F_07_7D_6D_66_00_39_06_3F;
    localparam logic [71:0] F7 = 72'h7F_07_7D_6D_66_00_39_71_3F;

    always #5 clk = ~clk;

    display_formatter #(.BLINK_FRAMES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frame_tick   (frame_tick),
        .display_bits (display_bits),
        .busy         (busy),
        .frame_missed (frame_missed),
        .dbg_state    (dbg_state)
    );

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_digit(input logic [3:0] a, input logic [6:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // wr_cyc: -1 none, 0 same edge as the tick, k>0 on edge k. miss_cyc: -1 none, else extra tick on edge miss_cyc.
    task automatic run_frame(input string tag, input int wr_cyc, input logic [3:0] a,
                             input logic [6:0] d, input int miss_cyc);
        logic [71:0] old_v;
        logic [71:0] exp_v;
        int          nb;
        int          nm;
        logic        early;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        nb = 0; nm = 0; early = 1'b0;
        @(negedge clk);
        old_v = display_bits;
        frame_tick = 1'b1;
        if (wr_cyc == 0) begin
            wr_en = 1'b1; wr_addr = a; wr_data = d;
        end
        @(negedge clk);
        frame_tick = 1'b0; wr_en = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (i == wr_cyc) begin
                wr_en = 1'b1; wr_addr = a; wr_data = d;
            end
            if (i == miss_cyc) frame_tick = 1'b1;
            if (busy) nb++;
            if (frame_missed) nm++;
            if (display_bits !== old_v) early = 1'b1;
            @(negedge clk);
            wr_en = 1'b0; frame_tick = 1'b0;
        end
        check($sformatf("%s.busy_cycles", tag), 72'(nb), 72'd10);
        check($sformatf("%s.early_change", tag), 72'(early), 72'd0);
        check($sformatf("%s.missed_pulses", tag), 72'(nm), (miss_cyc > 0) ? 72'd1 : 72'd0);
        check($sformatf("%s.busy_after", tag), 72'(busy), 72'd0);
        check($sformatf("%s.display", tag), display_bits, exp_v);
        @(negedge clk);
        check($sformatf("%s.idle_hold", tag), 72'(busy), 72'd0);
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 7'h05;
        repeat (3) @(negedge clk);
        rst = 1'b0; frame_tick = 1'b0; wr_en = 1'b0;
        check("rst.display", display_bits, 72'd0);
        check("rst.busy", 72'(busy), 72'd0);
        check("rst.missed", 72'(frame_missed), 72'd0);
        check("rst.state", 72'(dbg_state), 72'd0);
        @(negedge clk);
        check("rst.tick_ignored", 72'(busy), 72'd0);

        exp_q.push_back(72'd0);
        run_frame("rst_blank", -1, 4'd0, 7'h00, -1);

        for (int i = 0; i < 9; i++) write_digit(4'(i), 7'(i));
        exp_q.push_back(F0);
        run_frame("count", -1, 4'd0, 7'h00, -1);

        write_digit(4'd3, 7'h1A);
        exp_q.push_back(F1);
        run_frame("dp_a", -1, 4'd0, 7'h00, -1);
        write_digit(4'd3, 7'h2A);
        exp_q.push_back(F2);
        run_frame("blank", -1, 4'd0, 7'h00, -1);

        exp_q.push_back(F2);
        run_frame("wr_mid", 3, 4'd2, 7'h0C, -1);
        exp_q.push_back(F4);
        run_frame("wr_mid_next", -1, 4'd0, 7'h00, -1);

        write_digit(4'd12, 7'h00);
        exp_q.push_back(F4);
        run_frame("bad_addr", -1, 4'd0, 7'h00, -1);

        exp_q.push_back(F4);
        run_frame("wr_acc", 0, 4'd1, 7'h0F, -1);
        exp_q.push_back(F7);
        run_frame("wr_acc_next", -1, 4'd0, 7'h00, -1);

        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst.display", display_bits, 72'd0);
        check("mid_rst.busy", 72'(busy), 72'd0);
        @(negedge clk);
        check("mid_rst.no_commit", display_bits, 72'd0);
        exp_q.push_back(72'd0);
        run_frame("mid_rst_frame", -1, 4'd0, 7'h00, -1);

        do_reset();
        write_digit(4'd0, 7'h45);
        exp_q.push_back(72'h6D); exp_q.push_back(72'h6D); exp_q.push_back(72'h00);
        exp_q.push_back(72'h00); exp_q.push_back(72'h6D); exp_q.push_back(72'h6D);
        run_frame("blink0", -1, 4'd0, 7'h00, 3);
        for (int k = 1; k < 6; k++) run_frame($sformatf("blink%0d", k), -1, 4'd0, 7'h00, -1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/display_formatter.md
DISPLAY_FORMATTER -- requirements
Module: display_formatter

Interface
REQ-001 SHALL provide parameter BLINK_FRAMES, default 16, meaning accepted frames per blink half-period (legal range 2..255).
REQ-002 SHALL have clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have wr_en  input  1  digit register write strobe, one write per cycle.
REQ-005 SHALL have wr_addr  input  4  digit index 0..8; digit 0 occupies display_bits[7:0].
REQ-006 SHALL have wr_data  input  7  [3:0] hex value, [4] decimal point, [5] blank, [6] blink enable.
REQ-007 SHALL have frame_tick  input  1  single-cycle frame boundary pulse from the serial display driver (its timer overflow).
REQ-008 SHALL have display_bits  output  72  registered segment image consumed by the serial display driver.
REQ-009 SHALL have busy  output  1  high while a frame encode is in progress.
REQ-010 SHALL have frame_missed  output  1  single-cycle pulse when frame_tick arrives while busy.

Function
REQ-011 SHALL hold nine 7-bit digit registers, written with wr_data on any clock edge where wr_en=1 and wr_addr<=8.
REQ-012 SHALL ignore writes with wr_addr 9..15, with no state change.
REQ-013 SHALL implement FSM states IDLE, ENCODE and COMMIT.
REQ-014 In IDLE with frame_tick=1, the block SHALL copy all nine digit registers and the current blink_phase into shadow registers, clear digit index idx to 0, and enter ENCODE.
REQ-015 In ENCODE, the block SHALL encode shadow digit idx into staging[idx*8 +: 8] each cycle, then increment idx; after idx=8, it SHALL enter COMMIT.
REQ-016 In COMMIT, the block SHALL load display_bits from staging and return to IDLE.
REQ-017 Latency: the accept edge is edge 0; encodes occur on edges 1..9; display_bits SHALL update on edge 10, with all 72 bits changing on that single edge and never partially.
REQ-018 busy SHALL be 1 from the edge after acceptance through the COMMIT cycle, and 0 in IDLE.
REQ-019 Writes during ENCODE/COMMIT SHALL update the digit registers, take no effect on the frame in progress, and appear at the next accepted frame.
REQ-020 frame_tick while busy SHALL be ignored: frame_missed=1 for exactly the following cycle, with no blink count advance.
REQ-021 Segment byte format: bit7=dp, bits6:0=g..a, with 1 meaning lit.
REQ-022 Hex encoding SHALL map 0-F to 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
REQ-023 The digit byte SHALL be 00 if blank=1, or if blink=1 and shadow blink_phase=1; otherwise it SHALL be {dp, hex code}.
REQ-024 Blink counter (8-bit) SHALL increment on each accepted frame_tick; at BLINK_FRAMES-1, it SHALL wrap to 0 and toggle blink_phase on the same edge.
REQ-025 The shadow copy SHALL capture blink_phase before the toggle on the accept edge.
REQ-026 wr_en and frame_tick asserted on the same edge SHALL result in the shadow capturing the pre-write digit value; the write SHALL land in the digit register.

Reset
REQ-027 rst=1 SHALL force: state=IDLE, idx=0, display_bits=0, staging=0, busy=0, frame_missed=0, blink counter=0, blink_phase=0, all digit registers=7'b0100000 (blanked).
REQ-028 rst SHALL take priority over wr_en and frame_tick on the same edge.
REQ-029 rst asserted mid-ENCODE SHALL abandon the frame; display_bits SHALL read 0 on the next cycle, with no partial commit.

Verification
REQ-030 After reset, write digits 0..8 with values 0..8, then pulse frame_tick -> busy high for 10 cycles; display_bits = 7F_07_7D_6D_66_4F_5B_06_3F (digit 8 first), changing on edge 10 only.
REQ-031 Write digit 3 = 0x1A (dp, value A), tick -> byte 3 = F7; digit 3 = 0x2A (blank) -> byte 3 = 00.
REQ-032 Pulse frame_tick 3 cycles after an accepted tick -> frame_missed high for one cycle, one commit only, blink counter advanced by 1.
REQ-033 Digit 0 = 0x45 (blink, value 5), BLINK_FRAMES=2, issue 6 spaced ticks -> byte 0 sequence 6D,6D,00,00,6D,6D.
REQ-034 Write digit 2 during ENCODE -> current frame keeps the old byte; the next frame shows the new byte; wr_addr=12 leaves all digits unchanged.
REQ-035 Assert rst on edge 5 of an encode -> display_bits=0 and busy=0 after the reset edge; the next tick encodes all digits as blanked, giving all zeros.
